audio_in_beat_detector: RTL

//  Input-side consumer of Audio_Controller: pops mic samples via the read_audio_in / audio_in_available

---
 rtl/audio_pkg.sv | 17 +
 rtl/audio_mono_abs.sv | 32 +++
 rtl/audio_in_beat_detector.sv | 117 +++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio-input beat detector: sample width, default
// magnitude width, beat FSM states and the stereo sample bundle.
package audio_pkg;
  localparam int SAMPLE_W  = 32;
  localparam int MAG_W_DEF = 16;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    HOLD  = 2'd1,
    QUIET = 2'd2
  } beat_st_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_t;
endpackage

// File: rtl/audio_mono_abs.sv
// Stage 2: registered L/R mono mix, absolute value with saturation, and the
// magnitude slice fed to the window accumulator.
module audio_mono_abs
  import audio_pkg::*;
#(
  parameter int MAG_W = MAG_W_DEF
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             vld_in,
  input  stereo_t          smp,
  output logic [MAG_W-1:0] mag16
);
  logic signed [SAMPLE_W-1:0] mono;
  logic        [SAMPLE_W-1:0] mag;

  // Halving each channel first keeps the sum inside 32 bits; only -2^31 has no
  // positive twin, so it clamps to the largest positive value.
  always_comb begin
    mono = ($signed(smp.l) >>> 1) + ($signed(smp.r) >>> 1);
    if (mono == {1'b1, {(SAMPLE_W-1){1'b0}}})
      mag = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (mono[SAMPLE_W-1])
      mag = -mono;
    else
      mag = mono;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn)     mag16 <= '0;
    else if (vld_in) mag16 <= MAG_W'(mag >> (SAMPLE_W-1-MAG_W));
endmodule

// File: rtl/audio_in_beat_detector.sv
// Pops mic samples from Audio_Controller, tracks windowed mean magnitude and
// fires a one-cycle beat pulse with threshold, hysteresis and hold-off.
module audio_in_beat_detector
  import audio_pkg::*;
#(
  parameter int WIN_LOG2    = 8,
  parameter int MAG_W       = MAG_W_DEF,
  parameter int HOLDOFF_WIN = 2
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                enable,
  input  logic                audio_in_available,
  input  logic [SAMPLE_W-1:0] left_channel_audio_in,
  input  logic [SAMPLE_W-1:0] right_channel_audio_in,
  input  logic [MAG_W-1:0]    threshold,
  output logic                read_audio_in,
  output logic [MAG_W-1:0]    level,
  output logic                window_done,
  output logic                beat
);
  localparam int STAGES = 2;
  localparam int ACC_W  = MAG_W + WIN_LOG2;
  localparam int HOLD_W = (HOLDOFF_WIN > 0) ? $clog2(HOLDOFF_WIN + 1) : 1;

  logic [STAGES-1:0]   vld_pipe;   // [0] stage1 holds a sample, [1] stage2 holds a magnitude
  stereo_t             s1;
  logic [MAG_W-1:0]    mag16;
  logic [ACC_W-1:0]    acc, acc_sum;
  logic [WIN_LOG2-1:0] cnt;
  logic [MAG_W-1:0]    mean;
  logic                win_end;
  beat_st_t            state, nxt_state;
  logic [HOLD_W-1:0]   hold_cnt, nxt_hold;
  logic                fire;

  assign read_audio_in = resetn & enable & audio_in_available;

  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      vld_pipe <= '0;
      s1       <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], read_audio_in};
      if (read_audio_in) s1 <= {left_channel_audio_in, right_channel_audio_in};
    end

  audio_mono_abs #(.MAG_W(MAG_W)) u_mono_abs (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .vld_in   (vld_pipe[0]),
    .smp      (s1),
    .mag16    (mag16)
  );

  // The last sample of a window is folded in on the same cycle the mean is taken.
  assign acc_sum = acc + ACC_W'(mag16);
  assign mean    = acc_sum[ACC_W-1 -: MAG_W];
  assign win_end = vld_pipe[1] && (cnt == '1);

  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      acc         <= '0;
      cnt         <= '0;
      level       <= '0;
      window_done <= 1'b0;
      beat        <= 1'b0;
    end else begin
      window_done <= win_end;
      beat        <= win_end & fire;
      if (win_end) begin
        acc   <= '0;
        cnt   <= '0;
        level <= mean;
      end else if (vld_pipe[1]) begin
        acc <= acc_sum;
        cnt <= cnt + 1'b1;
      end
    end

  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      state    <= ARMED;
      hold_cnt <= '0;
    end else begin
      state    <= nxt_state;
      hold_cnt <= nxt_hold;
    end

  // Decisions happen only at window end; threshold is looked at only then.
  always_comb begin
    nxt_state = state;
    nxt_hold  = hold_cnt;
    fire      = 1'b0;
    if (win_end) begin
      case (state)
        ARMED:
          if (mean > threshold) begin
            fire = 1'b1;
            if (HOLDOFF_WIN == 0) begin
              nxt_state = QUIET;
            end else begin
              nxt_state = HOLD;
              nxt_hold  = HOLD_W'(HOLDOFF_WIN);
            end
          end
        HOLD: begin
          nxt_hold = hold_cnt - 1'b1;
          if (hold_cnt <= HOLD_W'(1)) nxt_state = QUIET;
        end
        QUIET:
          if (mean <= (threshold >> 1)) nxt_state = ARMED;
        default: nxt_state = ARMED;
      endcase
    end
  end
endmodule
